// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light sequencer: phase encoding and
// helpers that turn the per-instance phase lengths into timer reload values.
package tl_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t ST_RED    = 2'd0;
  localparam phase_t ST_GREEN  = 2'd1;
  localparam phase_t ST_YELLOW = 2'd2;

  // Illegal codes fall back to the RED length, matching the fail-safe recovery.
  function automatic int unsigned phase_cycles(input phase_t      ph,
                                               input int unsigned red_c,
                                               input int unsigned green_c,
                                               input int unsigned yellow_c);
    case (ph)
      ST_GREEN:  return green_c;
      ST_YELLOW: return yellow_c;
      default:   return red_c;
    endcase
  endfunction

  function automatic int timer_width(input int unsigned red_c,
                                     input int unsigned green_c,
                                     input int unsigned yellow_c);
    int unsigned m;
    m = red_c;
    if (green_c > m) m = green_c;
    if (yellow_c > m) m = yellow_c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down-counter that parks at zero and flags it; load wins over
// counting so a phase change and its new duration land on the same edge.
module tl_phase_timer #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_light.sv
// Single-intersection sequencer: RED -> GREEN -> YELLOW -> RED, each phase held
// for its parameterised number of cycles. Lamps are decoded from state alone.
module traffic_light
  import tl_pkg::*;
#(
  parameter int RED_CYCLES    = 10,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  output logic red,
  output logic yellow,
  output logic green
);

  localparam int TW = timer_width(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES);

  phase_t          state;
  phase_t          state_nxt;
  logic            done;
  logic            load;
  logic [TW-1:0]   load_val;

  // An illegal code reloads immediately so recovery always gets a full RED.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_RED: begin
        if (done) begin
          state_nxt = ST_GREEN;
          load      = 1'b1;
        end
      end
      ST_GREEN: begin
        if (done) begin
          state_nxt = ST_YELLOW;
          load      = 1'b1;
        end
      end
      ST_YELLOW: begin
        if (done) begin
          state_nxt = ST_RED;
          load      = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RED;
        load      = 1'b1;
      end
    endcase
    load_val = TW'(phase_cycles(state_nxt, RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES) - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RED;
    end else begin
      state <= state_nxt;
    end
  end

  tl_phase_timer #(
    .WIDTH   (TW),
    .RST_VAL (TW'(RED_CYCLES - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  always_comb begin
    red    = 1'b0;
    yellow = 1'b0;
    green  = 1'b0;
    case (state)
      ST_GREEN:  green  = 1'b1;
      ST_YELLOW: yellow = 1'b1;
      default:   red    = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: default and short-period instances checked every
// cycle against an elapsed-edge model, plus literal pins at key edges.
module tb_traffic_light;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic red_a, yellow_a, green_a;
  logic red_b, yellow_b, green_b;

  int n_cmp = 0;
  int n_bad = 0;

  int k_a = 0;
  int k_b = 0;
  bit chk_a = 1'b1;
  bit seu_pending = 1'b0;
  bit seu_done = 1'b0;

  int       pin_a_e[9] = '{9, 10, 17, 18, 20, 21, 31, 39, 42};
  int       pin_a_s[9] = '{0, 1, 1, 2, 2, 0, 1, 2, 0};
  int       pin_b_e[5] = '{1, 2, 3, 4, 5};
  int       pin_b_s[5] = '{1, 1, 2, 0, 1};

  traffic_light dut_a (
    .clk    (clk),
    .rst    (rst),
    .red    (red_a),
    .yellow (yellow_a),
    .green  (green_a)
  );

  traffic_light #(
    .RED_CYCLES    (1),
    .GREEN_CYCLES  (2),
    .YELLOW_CYCLES (1)
  ) dut_b (
    .clk    (clk),
    .rst    (rst),
    .red    (red_b),
    .yellow (yellow_b),
    .green  (green_b)
  );

  always #5 clk = ~clk;

  // Phase after k edges since release: position within the R+G+Y period.
  function automatic logic [1:0] exp_phase(input int k, input int r, input int g, input int y);
    int p;
    p = k % (r + g + y);
    if (p < r) return 2'd0;
    if (p < r + g) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [2:0] lamps(input logic [1:0] ph);
    if (ph == 2'd1) return 3'b001;
    if (ph == 2'd2) return 3'b010;
    return 3'b100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Elapsed-edge model; a recovered illegal state restarts instance a's period.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_a = 0;
      k_b = 0;
    end else begin
      k_b = k_b + 1;
      if (seu_pending && !seu_done) begin
        k_a = 0;
        seu_done = 1'b1;
      end else begin
        k_a = k_a + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_a)
      check("model_a", {dut_a.state, red_a, yellow_a, green_a},
            {exp_phase(k_a, 10, 8, 3), lamps(exp_phase(k_a, 10, 8, 3))});
    check("onehot_a", $countones({red_a, yellow_a, green_a}), 1);
    check("model_b", {dut_b.state, red_b, yellow_b, green_b},
          {exp_phase(k_b, 1, 2, 1), lamps(exp_phase(k_b, 1, 2, 1))});
    check("onehot_b", $countones({red_b, yellow_b, green_b}), 1);
  end

  initial begin
    #1;
    check("rst_hold_a", {dut_a.state, red_a, yellow_a, green_a}, 5'b00100);
    #11;
    check("rst_hold_a2", {dut_a.state, red_a, yellow_a, green_a}, 5'b00100);
    check("rst_hold_b", {dut_b.state, red_b, yellow_b, green_b}, 5'b00100);
    #5 rst = 1'b1;

    for (int e = 1; e <= 1000; e++) begin
      edges(1);
      for (int i = 0; i < 9; i++)
        if (pin_a_e[i] == e)
          check("pin_a", {dut_a.state, red_a, yellow_a, green_a},
                {pin_a_s[i][1:0], lamps(pin_a_s[i][1:0])});
      for (int i = 0; i < 5; i++)
        if (pin_b_e[i] == e)
          check("pin_b", {dut_b.state, red_b, yellow_b, green_b},
                {pin_b_s[i][1:0], lamps(pin_b_s[i][1:0])});
    end

    // Asynchronous reset between edges must show RED before the next edge.
    #2 rst = 1'b0;
    #1;
    check("async_rst", {dut_a.state, red_a, yellow_a, green_a}, 5'b00100);
    @(posedge clk);
    #3 rst = 1'b1;

    edges(13);
    check("pre_mid_rst", {dut_a.state, green_a}, 3'b011);
    edges(1);
    check("edge14_green", {dut_a.state, green_a}, 3'b011);
    #1 rst = 1'b0;
    #1;
    check("mid_rst", {dut_a.state, red_a, yellow_a, green_a}, 5'b00100);
    @(posedge clk);
    #3 rst = 1'b1;
    edges(9);
    check("post_rst_red", {dut_a.state, red_a}, 3'b001);
    edges(1);
    check("post_rst_green", {dut_a.state, green_a}, 3'b011);

    // Upset the state register for one cycle while in GREEN.
    edges(2);
    chk_a = 1'b0;
    force dut_a.state = 2'd3;
    #1;
    check("illegal_lamps", {red_a, yellow_a, green_a}, 3'b100);
    release dut_a.state;
    seu_pending = 1'b1;
    edges(1);
    check("illegal_recover", {dut_a.state, red_a, yellow_a, green_a}, 5'b00100);
    chk_a = 1'b1;
    edges(9);
    check("recover_full_red", {dut_a.state, red_a}, 3'b001);
    edges(1);
    check("recover_green", {dut_a.state, green_a}, 3'b011);
    edges(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_light.md
Name: traffic_light

Overview:
- Single-intersection traffic-light sequencer. Cycles RED -> GREEN -> YELLOW -> RED indefinitely, holding each phase for a parameterised number of clock cycles.
- Drives three one-hot lamp outputs.
- Stand-alone leaf block; lamp outputs go to pad/driver logic.
- The current phase register is named state and is readable hierarchically by benches.

Parameters:
- RED_CYCLES, 10, clock cycles the RED phase is held (>=1)
- GREEN_CYCLES, 8, clock cycles the GREEN phase is held (>=1)
- YELLOW_CYCLES, 3, clock cycles the YELLOW phase is held (>=1)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
- red  output  1  red lamp, high during RED phase
- yellow  output  1  yellow lamp, high during YELLOW phase
- green  output  1  green lamp, high during GREEN phase

Behaviour:
- State register state is 2 bits wide. Encoding: RED=0, GREEN=1, YELLOW=2. Code 3 is illegal.
- Phase timer is a down-counter. Width is $clog2 of the largest parameter, minimum 1 bit.
- Reset (rst=0): takes effect immediately, with no clock needed.
  - state=RED, timer=RED_CYCLES-1
  - red=1, yellow=0, green=0
  - Holds for as long as rst=0.
- Each rising edge with rst=1:
  - If timer!=0: timer decrements; state unchanged.
  - If timer==0: state advances RED->GREEN, GREEN->YELLOW, YELLOW->RED. Timer loads (new phase's CYCLES)-1.
- Each phase therefore lasts exactly its CYCLES count of rising edges.
  - Full period = RED+GREEN+YELLOW = 21 cycles at defaults.
- Counting edges from reset release (edge 1 = first rising edge with rst=1), at defaults:
  - edge 10: RED -> GREEN
  - edge 18: GREEN -> YELLOW
  - edge 21: YELLOW -> RED
  - edge 31: RED -> GREEN again
- Outputs are Moore, decoded from state only.
  - Exactly one lamp is high at all times.
  - Lamps change in the same cycle as state.
  - No lamp is ever combinationally glitched by the timer.
- Illegal state 3 (SEU etc.):
  - Outputs decode as red=1, others 0 (fail-safe).
  - Next edge forces state=RED, timer=RED_CYCLES-1.
- CYCLES=1: that phase lasts a single cycle. Timer loads 0 and transitions on the next edge.
- Reset asserted mid-phase: immediate return to RED with a full RED duration after release. No partial phase is remembered.
- No other inputs. Free-running after reset.

Decomposition:
- Shared package tl_pkg:
  - state encoding constants ST_RED=2'd0, ST_GREEN=2'd1, ST_YELLOW=2'd2
  - phase_t typedef (2-bit)
  - function returning the duration for a given phase
- One sub-module: tl_phase_timer
  - Loadable down-counter with a zero flag.
  - Parameter WIDTH.
  - Inputs: clk, rst, load, load_val.
  - Output: done (timer==0).
- Top holds the state register, next-state logic, duration mux and output decode.

Test Plan:
- Reset: hold rst=0 for 17 ns with clk at 10 ns period -> state=0, red=1, yellow=0, green=0 throughout. Asynchronous effect is checked by asserting rst between clock edges, after which outputs read RED before the next edge.
- Default sequence: release reset and run 100 cycles -> transitions at edges 10 (state=1, G), 18 (state=2, Y), 21 (state=0, R), 31, 39, 42, …; period 21 verified across at least 4 periods.
- One-hot invariant: every cycle of a 1000-cycle run -> red+yellow+green==1 and lamp matches state.
- Mid-phase reset: pulse rst=0 at edge 14 (GREEN) -> immediately red=1, state=0. After release, GREEN appears exactly 10 edges later.
- Parameter override RED_CYCLES=1, GREEN_CYCLES=2, YELLOW_CYCLES=1 -> period 4, pattern R,G,G,Y repeating from edge 1.
- Illegal state: force state=3 for one cycle, then release -> outputs red only during the forced cycle. Next edge gives state=0 with a full RED duration.
